// File: rtl/adder_chunked_nbit.sv
// adder_chunked_nbit: multi-cycle unsigned adder, CHUNK_BITS per clock, LSB first.
// Ports: clk, rst (async high), start, a, b, carry_in -> busy, done, sum, overflow.
// Build option: define ADDER_SIGNED_OVERFLOW_EN to make overflow report
// two's-complement signed overflow instead of the unsigned carry-out.
module adder_chunked_nbit #(
    parameter int NUM_BITS   = 16,
    parameter int CHUNK_BITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [NUM_BITS-1:0] a,
    input  logic [NUM_BITS-1:0] b,
    input  logic                carry_in,
    output logic                busy,
    output logic                done,
    output logic [NUM_BITS-1:0] sum,
    output logic                overflow
);

    localparam int NUM_CHUNKS = NUM_BITS / CHUNK_BITS;
    localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_BITS-1:0] a_q, a_d;
    logic [NUM_BITS-1:0] b_q, b_d;
    logic                carry_q, carry_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [NUM_BITS-1:0] sum_q, sum_d;
    logic                overflow_q, overflow_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [CHUNK_BITS-1:0] a_chunk;
    logic [CHUNK_BITS-1:0] b_chunk;
    logic [CHUNK_BITS:0]   chunk_sum;
    logic                  last_chunk;
    logic                  final_ovf;
    int                    base;

    // Slice the current chunk out of the latched operands.
    always_comb begin
        base       = int'(idx_q) * CHUNK_BITS;
        a_chunk    = a_q[base +: CHUNK_BITS];
        b_chunk    = b_q[base +: CHUNK_BITS];
        chunk_sum  = {1'b0, a_chunk} + {1'b0, b_chunk}
                   + {{CHUNK_BITS{1'b0}}, carry_q};
        last_chunk = (idx_q == LAST_IDX);
    end

`ifdef ADDER_SIGNED_OVERFLOW_EN
    // On the last chunk, chunk_sum[CHUNK_BITS-1] is the final sum MSB.
    always_comb begin
        final_ovf = (a_q[NUM_BITS-1] == b_q[NUM_BITS-1])
                 && (chunk_sum[CHUNK_BITS-1] != a_q[NUM_BITS-1]);
    end
`else
    always_comb begin
        final_ovf = chunk_sum[CHUNK_BITS];
    end
`endif

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        carry_d    = carry_q;
        idx_d      = idx_q;
        sum_d      = sum_q;
        overflow_d = overflow_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = carry_in;
                    idx_d   = '0;
                    state_d = S_ADD;
                    busy_d  = 1'b1;
                end else begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            end
            S_ADD: begin
                sum_d[base +: CHUNK_BITS] = chunk_sum[CHUNK_BITS-1:0];
                carry_d = chunk_sum[CHUNK_BITS];
                if (last_chunk) begin
                    overflow_d = final_ovf;
                    idx_d      = '0;
                    state_d    = S_DONE;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            carry_q    <= 1'b0;
            idx_q      <= '0;
            sum_q      <= '0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            carry_q    <= carry_d;
            idx_q      <= idx_d;
            sum_q      <= sum_d;
            overflow_q <= overflow_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign sum      = sum_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_adder_chunked_nbit.sv
// tb_adder_chunked_nbit: directed vectors plus handshake corner sequences
// for adder_chunked_nbit at NUM_BITS=16, CHUNK_BITS=4.
module tb_adder_chunked_nbit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        carry_in;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        overflow;

    int tests;
    int failed;

    adder_chunked_nbit #(
        .NUM_BITS  (16),
        .CHUNK_BITS(4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .carry_in(carry_in),
        .busy    (busy),
        .done    (done),
        .sum     (sum),
        .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        carry;
        logic        sovf;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic pick_ovf(input logic carry, input logic sovf);
`ifdef ADDER_SIGNED_OVERFLOW_EN
        return sovf;
`else
        return carry;
`endif
    endfunction

    // Issue one request from a negedge; checks busy length, result, and
    // that done drops after one cycle.
    task automatic do_op(input string name, input logic [15:0] va,
                         input logic [15:0] vb, input logic vc,
                         input logic [15:0] esum, input logic eovf);
        int n;
        int nbusy;
        a        = va;
        b        = vb;
        carry_in = vc;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n     = 0;
        nbusy = 0;
        while (!done && n < 20) begin
            if (busy) nbusy++;
            @(negedge clk);
            n++;
        end
        chk({name, " done_seen"}, {31'd0, done}, 32'd1);
        chk({name, " busy_cycles"}, nbusy, 32'd4);
        chk({name, " sum"}, {16'd0, sum}, {16'd0, esum});
        chk({name, " ovf"}, {31'd0, overflow}, {31'd0, eovf});
        @(negedge clk);
        chk({name, " done_pulse"}, {30'd0, done, busy}, 32'd0);
        chk({name, " sum_hold"}, {15'd0, overflow, sum},
            {15'd0, eovf, esum});
    endtask

    initial begin
        int n;
        int ndone;
        int gap;
        tests    = 0;
        failed   = 0;
        rst      = 1'b0;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        carry_in = 1'b0;

        vecs[0]  = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[1]  = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2]  = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[3]  = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[4]  = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[5]  = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[6]  = '{16'h0001, 16'h0002, 1'b1, 16'h0004, 1'b0, 1'b0};
        vecs[7]  = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
        vecs[8]  = '{16'hABCD, 16'h1234, 1'b0, 16'hBE01, 1'b0, 1'b0};
        vecs[9]  = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        vecs[10] = '{16'h7FFF, 16'h7FFF, 1'b1, 16'hFFFF, 1'b0, 1'b1};

        // Async reset between edges.
        #2 rst = 1'b1;
        #1;
        chk("reset_outputs", {13'd0, busy, done, overflow, sum}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_hold", {13'd0, busy, done, overflow, sum}, 32'd0);
        end

        for (int i = 0; i < 11; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
                  vecs[i].sum, pick_ovf(vecs[i].carry, vecs[i].sovf));
        end

        // Back-to-back: start held through DONE.
        a        = 16'h0F0F;
        b        = 16'h00F1;
        carry_in = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("b2b first_done", {31'd0, done}, 32'd1);
        chk("b2b first_sum", {15'd0, overflow, sum}, 32'h1000);
        gap = 0;
        @(negedge clk);
        gap++;
        chk("b2b re_add", {30'd0, busy, done}, 32'd2);
        while (!done && gap < 20) begin
            @(negedge clk);
            gap++;
        end
        start = 1'b0;
        chk("b2b gap", gap, 32'd5);
        chk("b2b second_sum", {15'd0, overflow, sum}, 32'h1000);
        @(negedge clk);
        chk("b2b to_idle", {30'd0, busy, done}, 32'd0);

        // Start and operand changes during ADD are ignored.
        a        = 16'h1234;
        b        = 16'h4321;
        carry_in = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start    = 1'b1;
        a        = 16'hFFFF;
        b        = 16'hFFFF;
        carry_in = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) begin
                ndone++;
                chk("midchg sum", {15'd0, overflow, sum}, 32'h5555);
            end
            @(negedge clk);
        end
        chk("midchg done_count", ndone, 32'd1);

        // Reset mid-ADD aborts with no done.
        a        = 16'hFFFF;
        b        = 16'h0001;
        carry_in = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst outputs", {13'd0, busy, done, overflow, sum}, 32'd0);
        @(negedge clk);
        rst   = 1'b0;
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            if (done || busy) ndone++;
            @(negedge clk);
        end
        chk("midrst no_done", ndone, 32'd0);
        do_op("after_rst", 16'h0001, 16'h0002, 1'b1, 16'h0004, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/adder_chunked_nbit.md
Name: adder_chunked_nbit

Overview:
- Parametrised multi-cycle unsigned adder. Next generation of the team's fixed 4-bit combinational adder.
- Adds two NUM_BITS operands plus carry-in, processing CHUNK_BITS per clock, LSB chunk first, with a ripple carry register between chunks.
- Uses a start/busy/done handshake. Sits in datapaths where a wide single-cycle carry chain would miss timing.

Parameters:
- NUM_BITS, 16: operand and sum width. Must be a multiple of CHUNK_BITS and at least CHUNK_BITS.
- CHUNK_BITS, 4: bits added per clock cycle. NUM_CHUNKS = NUM_BITS / CHUNK_BITS.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled on rising clk while state is IDLE or DONE.
- a  input  NUM_BITS  operand A; captured when start is accepted.
- b  input  NUM_BITS  operand B; captured when start is accepted.
- carry_in  input  1  carry into the LSB; captured when start is accepted.
- busy  output  1  high while state is ADD.
- done  output  1  one-cycle pulse; sum and overflow are valid.
- sum  output  NUM_BITS  result, low NUM_BITS bits of a + b + carry_in.
- overflow  output  1  carry out of the MSB (bit NUM_BITS of the full result).

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset, on assertion and without waiting for clk:
  - state goes to IDLE.
  - busy=0, done=0, sum=0, overflow=0.
  - Operand registers, carry register and chunk counter clear to 0.
- States: IDLE, ADD, DONE.
- IDLE:
  - With start=1 at the edge: latch a, b and carry_in, set chunk index to 0, go to ADD.
  - With start=0: stay in IDLE.
- ADD, at each edge:
  - Compute chunk[i] = a_chunk[i] + b_chunk[i] + carry_reg, CHUNK_BITS+1 bits wide.
  - Write the low CHUNK_BITS bits into sum bits [(i+1)*CHUNK_BITS-1 : i*CHUNK_BITS].
  - carry_reg <= bit CHUNK_BITS of the chunk sum; increment the index.
  - After the edge that processes chunk NUM_CHUNKS-1: overflow <= final carry, go to DONE.
- DONE lasts exactly one cycle with done=1.
  - start=1 at that edge: accepted as a new request (back-to-back), go to ADD.
  - Otherwise: go to IDLE.
- Latency: start sampled at edge E. done is high in the cycle after edge E+NUM_CHUNKS, so throughput is one result per NUM_CHUNKS+1 cycles.
- start is ignored while in ADD; changes to a, b and carry_in during ADD have no effect.
- sum and overflow hold their last result until the next accepted start.
  - During ADD, the upper chunks of sum still show stale data.
  - sum and overflow are only guaranteed while done=1 or in IDLE after DONE.
- Arithmetic is unsigned and modulo 2^NUM_BITS; overflow is the true carry-out.
- If NUM_CHUNKS=1, ADD lasts one cycle.
- rst asserted mid-ADD aborts the operation. No done pulse is produced for it; all outputs return to reset values.

Optional Feature:
- Macro: ADDER_SIGNED_OVERFLOW_EN.
- Defined: overflow reports two's-complement signed overflow, i.e. (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]). carry_in counts as part of the addition.
- Not defined: overflow is the unsigned carry-out described above.
- Timing and handshake are identical in both builds.

Test Plan (NUM_BITS=16, CHUNK_BITS=4):
- Reset then idle: assert rst between edges -> busy=0, done=0, sum=0x0000, overflow=0 immediately; outputs stay there with start=0.
- Basic add: a=0x1234, b=0x4321, carry_in=0, start pulse -> busy high 4 cycles, then done for 1 cycle with sum=0x5555, overflow=0.
- Full carry ripple: a=0xFFFF, b=0x0001, carry_in=0 -> sum=0x0000, overflow=1. Also a=0xFFFF, b=0xFFFF, carry_in=1 -> sum=0xFFFF, overflow=1. With ADDER_SIGNED_OVERFLOW_EN, a=0x7FFF, b=0x0001 -> overflow=1.
- Back-to-back: start held high through DONE with a=0x0F0F, b=0x00F1 -> first result done, next edge returns to ADD; second done exactly 5 cycles after the first, sum=0x1000, overflow=0.
- Start and operand changes during ADD: pulse start and change a/b mid-operation -> no restart, result matches the originally latched operands, exactly one done pulse.
- Reset mid-operation: assert rst after 2 ADD cycles -> outputs zero at once, no done; next request a=0x0001, b=0x0002, carry_in=1 -> sum=0x0004.
